// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase arbiter.
// `PED_WALK_EN adds a fourth request slot for the pedestrian walk phase.
package traffic_pkg;

`ifdef PED_WALK_EN
  localparam int unsigned N_REQ = 4;
  localparam logic [2:0]  PED_IDX = 3'd4;
`else
  localparam int unsigned N_REQ = 3;
`endif

  typedef enum logic [1:0] {
    LT_RED    = 2'b00,
    LT_GREEN  = 2'b01,
    LT_YELLOW = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    PH_ALL_RED,
    PH_GREEN,
    PH_YELLOW,
    PH_WALK
  } phase_t;

  // Requester index: 0 = none, 1..3 = approaches, 4 = pedestrian.
  typedef logic [2:0] approach_t;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic light_t phase_light(input phase_t p);
    light_t l;
    l = LT_RED;
    case (p)
      PH_GREEN:  l = LT_GREEN;
      PH_YELLOW: l = LT_YELLOW;
      default:   l = LT_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first pending requester after last_served,
// wrapping 1 -> 2 -> ... -> N -> 1.
module rr_pick
  import traffic_pkg::*;
#(
  parameter int unsigned N = N_REQ
) (
  input  logic [N-1:0] pending,
  input  approach_t    last_served,
  output approach_t    winner,
  output logic         valid
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  int unsigned idx;

  // NOTE: every variable written here gets a default first, so no latch can form
  // on paths where no requester matches.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= int'(N); k++) begin
      idx = (int'(last_served) - 1 + k) % N;
      if (!valid && pending[idx[IW-1:0]]) begin
        valid  = 1'b1;
        winner = approach_t'(idx + 1);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Round-robin green-phase scheduler for a three-approach intersection with
// min/max green, yellow and all-red timing. `PED_WALK_EN adds a pedestrian walk phase.
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN   = 4,
  parameter int unsigned MAX_GREEN   = 12,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1,
  parameter int unsigned WALK_TIME   = 6
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
`ifdef PED_WALK_EN
  input  logic       PedReq,
  output logic       Walk,
`endif
  output logic [1:0] L1,
  output logic [1:0] L2,
  output logic [1:0] L3,
  output logic [1:0] Active
);

  localparam int unsigned TMAX = max_of(max_of(MIN_GREEN, MAX_GREEN),
                                        max_of(max_of(YELLOW_TIME, ALLRED_TIME), WALK_TIME));
  localparam int unsigned TW   = $clog2(TMAX) + 1;

  localparam logic [TW:0] MIN_T    = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0] MAX_T    = (TW+1)'(MAX_GREEN);
  localparam logic [TW:0] YELLOW_T = (TW+1)'(YELLOW_TIME);
  localparam logic [TW:0] ALLRED_T = (TW+1)'(ALLRED_TIME);
  localparam logic [TW:0] WALK_T   = (TW+1)'(WALK_TIME);

  phase_t           phase_q, phase_d;
  logic [TW-1:0]    timer_q, timer_d, timer_inc;
  logic [TW:0]      elapsed;
  logic [N_REQ-1:0] pending_q, pending_d, sense, grant, serving;
  approach_t        last_q, last_d, cur_q, cur_d, rr_winner;
  logic             rr_valid, enter_serve, own_req, other_pending;
  light_t           l1_q, l1_d, l2_q, l2_d, l3_q, l3_d, next_light;
  logic [1:0]       active_q, active_d;
  logic             walk_q, walk_d;

`ifdef PED_WALK_EN
  assign sense = {PedReq, S3, S2, S1};
`else
  assign sense = {S3, S2, S1};
`endif

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .pending     (pending_q),
    .last_served (last_q),
    .winner      (rr_winner),
    .valid       (rr_valid)
  );

  // timer_q counts from 0 on phase entry; elapsed is the cycles spent so far, this one included.
  assign elapsed     = {1'b0, timer_q} + (TW+1)'(1);
  assign timer_inc   = (&timer_q) ? timer_q : timer_q + TW'(1);
  assign enter_serve = (phase_q == PH_ALL_RED) && (elapsed >= ALLRED_T) && rr_valid;

  always_comb begin
    own_req       = 1'b0;
    other_pending = 1'b0;
    grant         = '0;
    serving       = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (cur_q == approach_t'(i + 1)) begin
        own_req    = sense[i];
        serving[i] = (phase_q == PH_GREEN) || (phase_q == PH_WALK);
      end else begin
        other_pending = other_pending | pending_q[i];
      end
      grant[i] = enter_serve && (rr_winner == approach_t'(i + 1));
    end
    // A grant on this edge wins over a sensor set on the same edge.
    pending_d = (pending_q | (sense & ~serving)) & ~grant;
  end

  always_comb begin
    phase_d = phase_q;
    timer_d = timer_inc;
    last_d  = last_q;
    cur_d   = cur_q;
    case (phase_q)
      PH_ALL_RED: begin
        if (enter_serve) begin
          cur_d   = rr_winner;
          timer_d = '0;
          phase_d = PH_GREEN;
`ifdef PED_WALK_EN
          if (rr_winner == PED_IDX) phase_d = PH_WALK;
`endif
        end
      end
      PH_GREEN: begin
        if (elapsed >= MIN_T && other_pending && (!own_req || elapsed >= MAX_T)) begin
          phase_d = PH_YELLOW;
          timer_d = '0;
        end
      end
      PH_YELLOW: begin
        if (elapsed >= YELLOW_T) begin
          phase_d = PH_ALL_RED;
          timer_d = '0;
          last_d  = cur_q;
          cur_d   = '0;
        end
      end
      default: begin
        if (elapsed >= WALK_T) begin
          phase_d = PH_ALL_RED;
          timer_d = '0;
          last_d  = cur_q;
          cur_d   = '0;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered lights track the phase exactly.
  always_comb begin
    next_light = phase_light(phase_d);
    l1_d       = (cur_d == approach_t'(1)) ? next_light : LT_RED;
    l2_d       = (cur_d == approach_t'(2)) ? next_light : LT_RED;
    l3_d       = (cur_d == approach_t'(3)) ? next_light : LT_RED;
    active_d   = (phase_d == PH_GREEN || phase_d == PH_YELLOW) ? cur_d[1:0] : 2'd0;
    walk_d     = (phase_d == PH_WALK);
  end

  // NOTE: state uses non-blocking assignments and the async reset restores every flop,
  // so the lights drop to RED the instant Reset rises.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      phase_q   <= PH_ALL_RED;
      timer_q   <= '0;
      pending_q <= '0;
      last_q    <= approach_t'(3);
      cur_q     <= '0;
      l1_q      <= LT_RED;
      l2_q      <= LT_RED;
      l3_q      <= LT_RED;
      active_q  <= 2'd0;
      walk_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      l1_q      <= l1_d;
      l2_q      <= l2_d;
      l3_q      <= l3_d;
      active_q  <= active_d;
      walk_q    <= walk_d;
    end
  end

  assign L1     = l1_q;
  assign L2     = l2_q;
  assign L3     = l3_q;
  assign Active = active_q;
`ifdef PED_WALK_EN
  assign Walk   = walk_q;
`else
  logic unused_walk;
  assign unused_walk = walk_q;
`endif

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Scoreboard bench for traffic_phase_arbiter: expected light frames are queued per scenario
// and popped one per clock. Builds with or without `PED_WALK_EN.
`timescale 1ns/1ps
module tb_traffic_phase_arbiter;

  localparam logic [1:0] R = 2'b00, G = 2'b01, Y = 2'b10;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       S1 = 1'b0, S2 = 1'b0, S3 = 1'b0;
  logic [1:0] L1, L2, L3, Active;
`ifdef PED_WALK_EN
  logic       PedReq = 1'b0;
  logic       Walk;
`endif

  int errors = 0;
  int checks = 0;

  // Frame layout: {walk, L1, L2, L3, Active}
  logic [8:0] sb[$];

  always #5 Clock = ~Clock;

  traffic_phase_arbiter dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .S1     (S1),
    .S2     (S2),
    .S3     (S3),
`ifdef PED_WALK_EN
    .PedReq (PedReq),
    .Walk   (Walk),
`endif
    .L1     (L1),
    .L2     (L2),
    .L3     (L3),
    .Active (Active)
  );

  function automatic logic [8:0] mk(input logic w, input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] c, input logic [1:0] act);
    return {w, a, b, c, act};
  endfunction

  function automatic logic [8:0] observed();
`ifdef PED_WALK_EN
    return {Walk, L1, L2, L3, Active};
`else
    return {1'b0, L1, L2, L3, Active};
`endif
  endfunction

  task automatic push(input logic [8:0] f, input int n);
    repeat (n) sb.push_back(f);
  endtask

  task automatic apply_reset();
    Reset = 1'b1;
    S1 = 1'b0; S2 = 1'b0; S3 = 1'b0;
`ifdef PED_WALK_EN
    PedReq = 1'b0;
`endif
    sb.delete();
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
  endtask

  // Safety monitor: never more than one light head off RED.
  always @(negedge Clock) begin
    if (!Reset) begin
      checks++;
      if (((L1 != R) ? 1 : 0) + ((L2 != R) ? 1 : 0) + ((L3 != R) ? 1 : 0) > 1) begin
        errors++;
        $display("FAIL one_light_at_a_time: L1=%b L2=%b L3=%b", L1, L2, L3);
      end
    end
  end

  task automatic test_reset();
    logic [8:0] exp, obs;
    int n;
    Reset = 1'b1;
    #1;
    checks++;
    obs = observed();
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, 9'd0);
    end
    apply_reset();
    push(9'd0, 10);
    n = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      exp = sb.pop_front(); obs = observed(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL idle_all_red cycle %0d: got %h expected %h", n, obs, exp);
      end
      n++;
    end
  endtask

  task automatic test_single_request_rest();
    logic [8:0] exp, obs;
    int n;
    apply_reset();
    S2 = 1'b1;
    push(9'd0, 1);
    push(mk(0, R, G, R, 2'd2), 23);
    n = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      exp = sb.pop_front(); obs = observed(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rest_on_green cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (n == 0) S2 = 1'b0;
      n++;
    end
  endtask

  task automatic test_max_green();
    logic [8:0] exp, obs;
    int n;
    apply_reset();
    S1 = 1'b1;
    push(9'd0, 1);
    push(mk(0, G, R, R, 2'd1), 12);
    push(mk(0, Y, R, R, 2'd1), 2);
    push(9'd0, 1);
    push(mk(0, R, R, G, 2'd3), 2);
    n = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      exp = sb.pop_front(); obs = observed(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL max_green cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (n == 1) S3 = 1'b1;
      if (n == 2) S3 = 1'b0;
      n++;
    end
    S1 = 1'b0;
  endtask

  task automatic test_min_green_gap_out();
    logic [8:0] exp, obs;
    int n;
    apply_reset();
    S1 = 1'b1;
    push(9'd0, 1);
    push(mk(0, G, R, R, 2'd1), 4);
    push(mk(0, Y, R, R, 2'd1), 2);
    push(9'd0, 1);
    push(mk(0, R, G, R, 2'd2), 1);
    n = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      exp = sb.pop_front(); obs = observed(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL min_green cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (n == 1) S2 = 1'b1;
      if (n == 2) S2 = 1'b0;
      if (n == 4) S1 = 1'b0;
      n++;
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp, obs;
    int n;
    apply_reset();
    S1 = 1'b1; S2 = 1'b1; S3 = 1'b1;
    push(9'd0, 1);
    push(mk(0, G, R, R, 2'd1), 4);
    push(mk(0, Y, R, R, 2'd1), 2);
    push(9'd0, 1);
    push(mk(0, R, G, R, 2'd2), 4);
    push(mk(0, R, Y, R, 2'd2), 2);
    push(9'd0, 1);
    push(mk(0, R, R, G, 2'd3), 5);
    n = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      exp = sb.pop_front(); obs = observed(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL round_robin cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (n == 0) begin S1 = 1'b0; S2 = 1'b0; S3 = 1'b0; end
      n++;
    end
  endtask

  task automatic test_reset_mid_phase();
    logic [8:0] exp, obs;
    int n;
    apply_reset();
    S2 = 1'b1;
    push(9'd0, 1);
    push(mk(0, R, G, R, 2'd2), 4);
    push(mk(0, R, Y, R, 2'd2), 1);
    n = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      exp = sb.pop_front(); obs = observed(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL pre_reset cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (n == 0) S2 = 1'b0;
      if (n == 1) S1 = 1'b1;
      if (n == 2) S1 = 1'b0;
      n++;
    end
    Reset = 1'b1;
    #1;
    checks++;
    obs = observed();
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs, 9'd0);
    end
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    // S1's request from before the reset must be gone.
    push(9'd0, 6);
    n = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      exp = sb.pop_front(); obs = observed(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL pending_cleared cycle %0d: got %h expected %h", n, obs, exp);
      end
      n++;
    end
  endtask

`ifdef PED_WALK_EN
  task automatic test_ped_walk();
    logic [8:0] exp, obs;
    int n;
    apply_reset();
    S3 = 1'b1;
    push(9'd0, 1);
    push(mk(0, R, R, G, 2'd3), 4);
    push(mk(0, R, R, Y, 2'd3), 2);
    push(9'd0, 1);
    push(mk(1, R, R, R, 2'd0), 6);
    push(9'd0, 2);
    n = 0;
    while (sb.size() > 0) begin
      @(posedge Clock); #1;
      exp = sb.pop_front(); obs = observed(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ped_walk cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (n == 0) S3 = 1'b0;
      if (n == 1) PedReq = 1'b1;
      if (n == 2) PedReq = 1'b0;
      n++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_request_rest();
    test_max_green();
    test_min_green_gap_out();
    test_round_robin();
    test_reset_mid_phase();
`ifdef PED_WALK_EN
    test_ped_walk();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
